spram_burst_master: RTL and testbench

//   Initiator for the single-port RAM (8-bit data, 6-bit address, we, out).

---
 rtl/spram_pkg.sv | 16 +
 rtl/singleport_ram.sv | 21 ++
 rtl/spram_rd_fifo.sv | 58 +++++
 rtl/spram_burst_master.sv | 148 ++++++++++++++
 tb/tb_spram_burst_master.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_pkg.sv
// Shared types and defaults for the single-port RAM burst master.
package spram_pkg;

   localparam int DW_DEF     = 8;
   localparam int AW_DEF     = 6;
   localparam int RD_LAT_MIN = 0;
   localparam int RD_LAT_MAX = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/singleport_ram.sv
// Single-port RAM with one cycle of read latency (read-before-write).
module singleport_ram #(
   parameter int DW = 8,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic          we,
   output logic [DW-1:0] out
);

   logic [DW-1:0] mem [2**AW];

   // Write on we, always register the addressed word onto out.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= data;
      out <= mem[addr];
   end

endmodule

// File: rtl/spram_rd_fifo.sv
// Small synchronous FIFO buffering RAM read data for the read stream.
module spram_rd_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [DW-1:0]              pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage write; the caller never pushes into a full buffer without popping.
   // NOTE: the data array has no reset; only pointers and count need a known state.
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_data = r_mem[r_rd_ptr];
   assign full     = (r_count == CW'(DEPTH));
   assign empty    = (r_count == '0);
   assign count    = r_count;

endmodule

// File: rtl/spram_burst_master.sv
// Burst initiator for a single-port RAM: command port, write stream in, read stream out.
module spram_burst_master
   import spram_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF,
   parameter int RD_LAT     = RD_LAT_MAX,
   parameter int OBUF_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_we,
   input  logic [DW-1:0] ram_out
);

   localparam int OCW = $clog2(OBUF_DEPTH + 1);
   localparam int CRW = $clog2(OBUF_DEPTH + RD_LAT + 1) + 1;

   state_t         r_state, w_next;
   logic [AW-1:0]  r_addr, r_cnt, r_last_addr;
   logic           w_wr_acc, w_issue, w_step;
   logic           w_push, w_pop, w_full, w_empty, w_credit_ok;
   logic [OCW-1:0] w_occ;
   logic [CRW-1:0] w_inflight, w_credit;

   // State register; reset aborts any burst and drops ram_we at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state and handshake/RAM strobes.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      ram_we    = 1'b0;
      w_wr_acc  = 1'b0;
      w_issue   = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next = cmd_write ? WRITE : READ;
         end
         WRITE: begin
            wr_ready = 1'b1;
            ram_we   = wr_valid;
            w_wr_acc = wr_valid;
            if (wr_valid && r_cnt == '0) w_next = IDLE;
         end
         READ: begin
            w_issue = w_credit_ok;
            if (w_credit_ok && r_cnt == '0) w_next = DRAIN;
         end
         DRAIN: begin
            if (w_inflight == '0 && w_empty) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_step = w_wr_acc | w_issue;

   // Burst address/count; r_last_addr keeps ram_addr steady outside active states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_cnt       <= '0;
         r_last_addr <= '0;
      end else if (cmd_ready && cmd_valid) begin
         r_addr <= cmd_addr;
         r_cnt  <= cmd_len;
      end else if (w_step) begin
         r_addr      <= r_addr + AW'(1);
         r_cnt       <= r_cnt - AW'(1);
         r_last_addr <= r_addr;
      end
   end

   // Read tag pipeline: a tag leaving the end marks valid ram_out this cycle.
   if (RD_LAT == 0) begin : g_lat0
      assign w_push     = w_issue;
      assign w_inflight = '0;
   end else begin : g_latn
      logic [RD_LAT-1:0] r_tag;

      // Shift issued-read markers in step with the RAM's read pipeline.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_tag <= '0;
         end else begin
            r_tag[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
         end
      end

      // Count reads that have been issued but not yet landed in the buffer.
      always_comb begin
         w_inflight = '0;
         for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CRW'(r_tag[i]);
      end

      assign w_push = r_tag[RD_LAT-1];
   end

   // Only issue when the buffer is guaranteed room for every read in flight.
   assign w_pop       = ~w_empty & rd_ready;
   assign w_credit    = CRW'(w_occ) + w_inflight - CRW'(w_pop);
   assign w_credit_ok = (w_credit < CRW'(OBUF_DEPTH));

   spram_rd_fifo #(
      .DW    (DW),
      .DEPTH (OBUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (ram_out),
      .pop       (w_pop),
      .pop_data  (rd_data),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_occ)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) w_push |-> (!w_full || w_pop));

   assign rd_valid = ~w_empty;
   assign busy     = (r_state != IDLE);
   assign ram_addr = (r_state == WRITE || r_state == READ) ? r_addr : r_last_addr;
   assign ram_data = wr_data;

endmodule

// File: tb/tb_spram_burst_master.sv
// Directed bench: burst master in front of a single-port RAM model.
module tb_spram_burst_master;

   localparam int DW = 8;
   localparam int AW = 6;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk, rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr, cmd_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_we;
   logic [DW-1:0] ram_out;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   wr_t           wr_log[$];
   logic [DW-1:0] rd_q[$];
   int            rd_cyc[$];
   logic [DW-1:0] tx[$];
   logic [DW-1:0] exp_q[$];
   int            stab_err = 0;
   int            gap_err = 0;
   int            max_occ = 0;
   logic          stall_pend = 1'b0;
   logic [DW-1:0] held = '0;
   logic          pat [4];

   spram_burst_master #(
      .DW (DW), .AW (AW), .RD_LAT (1), .OBUF_DEPTH (2)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_len (cmd_len),
      .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data),
      .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data (rd_data),
      .busy (busy),
      .ram_addr (ram_addr), .ram_data (ram_data), .ram_we (ram_we), .ram_out (ram_out)
   );

   singleport_ram #(.DW (DW), .AW (AW)) u_ram (
      .clk (clk), .addr (ram_addr), .data (ram_data), .we (ram_we), .out (ram_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pre-edge monitor: logs RAM writes, accepted read beats, stall stability, buffer fill.
   initial forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (ram_we) wr_log.push_back({ram_addr, ram_data});
      if (ram_we && !wr_valid) gap_err++;
      if (rd_valid && rd_ready) begin
         rd_q.push_back(rd_data);
         rd_cyc.push_back(cyc);
      end
      if (stall_pend && (!rd_valid || rd_data !== held)) stab_err++;
      stall_pend = rd_valid && !rd_ready;
      held       = rd_data;
      if (int'(dut.w_occ) > max_occ) max_occ = int'(dut.w_occ);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("cmd_accept_timeout", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic write_beats(input int gap);
      for (int i = 0; i < tx.size(); i++) begin
         int n = 0;
         if (i > 0) repeat (gap) begin
            wr_valid = 1'b0;
            @(negedge clk);
         end
         wr_valid = 1'b1;
         wr_data  = tx[i];
         while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (n >= 20) check("wr_ready_timeout", wr_ready, 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, busy, 0);
   endtask

   task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic toggle);
      int k = 0;
      rd_q.delete();
      rd_cyc.delete();
      rd_ready = 1'b1;
      cmd(1'b0, a, l);
      while (busy && k < 200) begin
         rd_ready = toggle ? pat[k % 4] : 1'b1;
         @(negedge clk);
         k++;
      end
      rd_ready = 1'b0;
      check("rd_burst_done", busy, 0);
   endtask

   task automatic check_rd(input string tag);
      check({tag, "_count"}, rd_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
         check($sformatf("%s_beat%0d", tag, i), rd_q[i], exp_q[i]);
   endtask

   task automatic check_wr(input string tag, input logic [AW-1:0] a0);
      check({tag, "_count"}, wr_log.size(), tx.size());
      for (int i = 0; i < tx.size() && i < wr_log.size(); i++) begin
         logic [AW-1:0] ea = a0 + AW'(i);
         check($sformatf("%s_addr%0d", tag, i), wr_log[i].a, ea);
         check($sformatf("%s_data%0d", tag, i), wr_log[i].d, tx[i]);
      end
   endtask

   initial begin
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: three-beat write at address 1
      wr_log.delete();
      tx = '{8'ha1, 8'hb2, 8'hc3};
      cmd(1'b1, 6'd1, 6'd2);
      check("t1_cmd_ready_low", cmd_ready, 0);
      write_beats(0);
      wait_idle("t1_idle");
      check_wr("t1_wr", 6'd1);
      check("t1_mem2", u_ram.mem[2], 8'hb2);

      // 2: read it back at full rate
      exp_q = '{8'ha1, 8'hb2, 8'hc3};
      read_burst(6'd1, 6'd2, 1'b0);
      check_rd("t2_rd");
      if (rd_cyc.size() == 3) begin
         check("t2_consec01", rd_cyc[1] - rd_cyc[0], 1);
         check("t2_consec12", rd_cyc[2] - rd_cyc[1], 1);
      end

      // 3: write across the top of the address space, then read back
      wr_log.delete();
      tx = '{8'hdf, 8'hee, 8'h11, 8'h22};
      cmd(1'b1, 6'd62, 6'd3);
      write_beats(0);
      wait_idle("t3_idle");
      check_wr("t3_wr", 6'd62);
      exp_q = '{8'hdf, 8'hee, 8'h11, 8'h22};
      read_burst(6'd62, 6'd3, 1'b0);
      check_rd("t3_rd");

      // 5: write with two-cycle gaps between beats
      wr_log.delete();
      gap_err = 0;
      tx = '{8'h44, 8'h55, 8'h66, 8'h77};
      cmd(1'b1, 6'd4, 6'd3);
      write_beats(2);
      wait_idle("t5_idle");
      check_wr("t5_wr", 6'd4);
      check("t5_we_in_gap", gap_err, 0);

      // 4: eight-beat read with rd_ready toggling 1,0,0,1
      stab_err = 0;
      max_occ  = 0;
      exp_q = '{8'h11, 8'h22, 8'hb2, 8'hc3, 8'h44, 8'h55, 8'h66, 8'h77};
      read_burst(6'd0, 6'd7, 1'b1);
      check_rd("t4_rd");
      check("t4_stall_stable", stab_err, 0);
      check("t4_occ_le2", max_occ <= 2, 1);

      // 6: reset in the middle of beat 2 of a six-beat write
      wr_log.delete();
      cmd(1'b1, 6'd20, 6'd5);
      wr_valid = 1'b1; wr_data = 8'h50;
      @(negedge clk);
      wr_data = 8'h51;
      @(negedge clk);
      wr_data = 8'h52;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_we_async_drop", ram_we, 0);
      wr_valid = 1'b0;
      @(negedge clk);
      check("t6_wr_count", wr_log.size(), 2);
      if (wr_log.size() >= 2) begin
         check("t6_wr0", {wr_log[0].a, wr_log[0].d}, {6'd20, 8'h50});
         check("t6_wr1", {wr_log[1].a, wr_log[1].d}, {6'd21, 8'h51});
      end
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ram_addr", ram_addr, 0);
      check("t6_rst_cmd_ready", cmd_ready, 1);
      check("t6_rst_rd_valid", rd_valid, 0);
      rst_n = 1'b1;
      wr_log.delete();
      tx = '{8'h99};
      cmd(1'b1, 6'd40, 6'd0);
      check("t6_accept_after_rst", busy, 1);
      write_beats(0);
      wait_idle("t6_idle");
      check_wr("t6_post", 6'd40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
